// File: rtl/inert_spi_resp.sv
// SPI responder modelling an inertial sensor: 16-bit mode-3 frames, a small
// register file served on MISO, and periodic pitch samples with a data-ready INT.
// All SPI inputs are oversampled by clk; edges come from the 3rd vs 2nd sync flop.
module inert_spi_resp #(
    parameter logic [15:0] SMPL_PERIOD = 16'd1000,
    parameter logic [7:0]  WHO_AM_I    = 8'h6A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    output logic        INT,
    input  logic [15:0] ptch_smpl,
    output logic        frm_err,
    output logic        setup_done
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    state_t      state, state_nxt;
    logic [2:0]  sclk_sync, ss_sync;
    logic [1:0]  mosi_sync;
    logic        sclk_rise, sclk_fall, ss_rise, ss_fall;
    logic [4:0]  bit_cnt;
    logic [15:0] rx_shreg;
    logic [7:0]  tx_shreg, rd_data;
    logic        ld_tx, shift_in, commit, abort, int_clr, tick;
    logic [7:0]  int1_ctrl, ctrl1_xl, ctrl2_g, pitchl, pitchh;
    logic [15:0] smpl_cnt;

    // Synchronisers; idle-high lines reset high so leaving reset makes no edge
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= 3'b111;
            ss_sync   <= 3'b111;
            mosi_sync <= 2'b00;
        end else begin
            sclk_sync <= {sclk_sync[1:0], SCLK};
            ss_sync   <= {ss_sync[1:0], SS_n};
            mosi_sync <= {mosi_sync[0], MOSI};
        end
    end

    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
    assign ss_rise   = ss_sync[1] & ~ss_sync[2];
    assign ss_fall   = ~ss_sync[1] & ss_sync[2];

    // Frame state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Frame sequencing and MISO drive
    always_comb begin
        state_nxt = state;
        shift_in  = 1'b0;
        abort     = 1'b0;
        commit    = 1'b0;
        MISO      = 1'b1;
        case (state)
            IDLE: begin
                if (ss_fall) state_nxt = ADDR;
            end
            ADDR: begin
                MISO     = 1'b0;
                shift_in = sclk_rise;
                if (ss_rise) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end else if (sclk_rise && bit_cnt == 5'd7) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                MISO     = tx_shreg[7];
                shift_in = sclk_rise;
                if (ss_rise) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end else if (sclk_rise && bit_cnt == 5'd15) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                MISO = tx_shreg[7];
                if (ss_rise) begin
                    commit    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Read mux; address is in rx_shreg[6:0] once the 8 header bits are in
    always_comb begin
        rd_data = 8'h00;
        case (rx_shreg[6:0])
            7'h0D:   rd_data = int1_ctrl;
            7'h0F:   rd_data = WHO_AM_I;
            7'h10:   rd_data = ctrl1_xl;
            7'h11:   rd_data = ctrl2_g;
            7'h22:   rd_data = pitchl;
            7'h23:   rd_data = pitchh;
            default: rd_data = 8'h00;
        endcase
    end

    // Receive shifter, bit counter and transmit byte
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt  <= 5'd0;
            rx_shreg <= 16'h0000;
            tx_shreg <= 8'h00;
            ld_tx    <= 1'b0;
        end else begin
            ld_tx <= shift_in && (state == ADDR) && (bit_cnt == 5'd7);
            if (state == IDLE && ss_fall) begin
                bit_cnt  <= 5'd0;
                rx_shreg <= 16'h0000;
            end else if (shift_in) begin
                rx_shreg <= {rx_shreg[14:0], mosi_sync[1]};
                if (bit_cnt != 5'd16) bit_cnt <= bit_cnt + 5'd1;
            end
            if (state == IDLE && ss_fall)
                tx_shreg <= 8'h00;
            else if (ld_tx)
                tx_shreg <= rd_data;
            else if (sclk_fall && state == DATA && bit_cnt >= 5'd9)
                tx_shreg <= {tx_shreg[6:0], 1'b0};
        end
    end

    // Writable registers; a write only lands when a complete frame closes
    always_ff @(posedge clk) begin
        if (rst) begin
            int1_ctrl <= 8'h00;
            ctrl1_xl  <= 8'h00;
            ctrl2_g   <= 8'h00;
        end else if (commit && !rx_shreg[15]) begin
            case (rx_shreg[14:8])
                7'h0D:   int1_ctrl <= rx_shreg[7:0];
                7'h10:   ctrl1_xl  <= rx_shreg[7:0];
                7'h11:   ctrl2_g   <= rx_shreg[7:0];
                default: ;
            endcase
        end
    end

    assign setup_done = (int1_ctrl == 8'h02);
    assign tick       = setup_done && (smpl_cnt == SMPL_PERIOD - 16'd1);
    assign int_clr    = commit && rx_shreg[15] && (rx_shreg[14:8] == 7'h23);

    // Sample timer, pitch capture and INT; a tick wins over a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            smpl_cnt <= 16'd0;
            pitchl   <= 8'h00;
            pitchh   <= 8'h00;
            INT      <= 1'b0;
        end else begin
            if (!setup_done || tick) smpl_cnt <= 16'd0;
            else                     smpl_cnt <= smpl_cnt + 16'd1;
            if (tick) begin
                {pitchh, pitchl} <= ptch_smpl;
                INT              <= 1'b1;
            end else if (int_clr) begin
                INT <= 1'b0;
            end
        end
    end

    // Frame error pulse on an incomplete frame
    always_ff @(posedge clk) begin
        if (rst) frm_err <= 1'b0;
        else     frm_err <= abort;
    end

endmodule

// File: tb/tb_inert_spi_resp.sv
// Self-checking bench for inert_spi_resp: table of frames, randomized
// register traffic against a register-map model, and timed corner sequences.
module tb_inert_spi_resp;

    localparam logic [15:0] P   = 16'd1000;
    localparam logic [7:0]  WHO = 8'h6A;

    logic        clk = 1'b0;
    logic        rst, SS_n, SCLK, MOSI, MISO, INT, frm_err, setup_done;
    logic [15:0] ptch_smpl;

    inert_spi_resp #(.SMPL_PERIOD(P), .WHO_AM_I(WHO)) dut (
        .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
        .MISO(MISO), .INT(INT), .ptch_smpl(ptch_smpl),
        .frm_err(frm_err), .setup_done(setup_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int err_pulses = 0;
    always @(negedge clk) if (frm_err === 1'b1) err_pulses <= err_pulses + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Mode-3 master: 5 clk half periods; MISO captured at each SCLK rise
    task automatic spi_frame(input logic [15:0] f, input int nbits, input bit end_frame,
                             input int raise_at, output logic [15:0] rcv);
        rcv  = 16'h0000;
        SS_n = 1'b0;
        clks(5);
        for (int i = 0; i < nbits; i++) begin
            SCLK = 1'b0;
            MOSI = (i < 16) ? f[4'(15 - i)] : 1'b1;
            clks(5);
            if (i < 16) rcv[4'(15 - i)] = MISO;
            SCLK = 1'b1;
            clks(5);
        end
        if (end_frame) begin
            for (int g = 0; g < 2000 && cyc < raise_at; g++) clks(1);
            SS_n = 1'b1;
        end
    endtask

    task automatic rd(input logic [6:0] a, output logic [7:0] b);
        logic [15:0] r;
        spi_frame({1'b1, a, 8'h00}, 16, 1'b1, 0, r);
        b = r[7:0];
        clks(10);
    endtask

    typedef struct {
        logic [15:0] frame;
        int          nbits;
        bit          chk_rd;
        logic [7:0]  exp_rd;
        bit          exp_err;
    } vec_t;

    vec_t        tbl[14];
    logic [7:0]  mdl[128];
    logic [15:0] r;
    logic [7:0]  b;
    int          e0, t, c2;

    initial begin
        tbl[0]  = '{16'h8F00, 16, 1'b1, 8'h6A, 1'b0};  // WHO_AM_I
        tbl[1]  = '{16'h0D02, 10, 1'b0, 8'h00, 1'b1};  // aborted in DATA
        tbl[2]  = '{16'h8D00, 16, 1'b1, 8'h00, 1'b0};  // INT1_CTRL untouched
        tbl[3]  = '{16'h0F55, 16, 1'b0, 8'h00, 1'b0};  // read-only target
        tbl[4]  = '{16'h8F00, 16, 1'b1, 8'h6A, 1'b0};
        tbl[5]  = '{16'hFF00, 16, 1'b1, 8'h00, 1'b0};  // unmapped
        tbl[6]  = '{16'h1033, 16, 1'b0, 8'h00, 1'b0};
        tbl[7]  = '{16'h9000, 16, 1'b1, 8'h33, 1'b0};
        tbl[8]  = '{16'h1144, 16, 1'b0, 8'h00, 1'b0};
        tbl[9]  = '{16'h9100, 16, 1'b1, 8'h44, 1'b0};
        tbl[10] = '{16'h9000,  3, 1'b0, 8'h00, 1'b1};  // aborted in ADDR
        tbl[11] = '{16'h9000, 16, 1'b1, 8'h33, 1'b0};
        tbl[12] = '{16'h1155, 18, 1'b0, 8'h00, 1'b0};  // extra rises in DONE
        tbl[13] = '{16'h9100, 18, 1'b1, 8'h55, 1'b0};

        rst = 1'b1; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0; ptch_smpl = 16'h0000;
        clks(3);
        chk("rst_miso", 32'(MISO), 32'd1);
        chk("rst_int", 32'(INT), 32'd0);
        chk("rst_frm_err", 32'(frm_err), 32'd0);
        chk("rst_setup", 32'(setup_done), 32'd0);
        rst = 1'b0;
        clks(5);

        for (int k = 0; k < 14; k++) begin
            e0 = err_pulses;
            spi_frame(tbl[k].frame, tbl[k].nbits, 1'b1, 0, r);
            clks(10);
            chk($sformatf("tbl%0d_err", k), 32'(err_pulses - e0), 32'(tbl[k].exp_err));
            chk($sformatf("tbl%0d_addr_miso", k), 32'(r[15:8]), 32'h0);
            chk($sformatf("tbl%0d_int", k), 32'(INT), 32'd0);
            chk($sformatf("tbl%0d_setup", k), 32'(setup_done), 32'd0);
            if (tbl[k].chk_rd) chk($sformatf("tbl%0d_rd", k), 32'(r[7:0]), 32'(tbl[k].exp_rd));
        end

        // Random register traffic against a plain register-map model
        rst = 1'b1; clks(2); rst = 1'b0; clks(3);
        for (int a = 0; a < 128; a++) mdl[a] = 8'h00;
        for (int k = 0; k < 40; k++) begin
            logic [6:0] addr;
            logic [7:0] data;
            bit         wr;
            case ($urandom_range(0, 6))
                0: addr = 7'h0D;
                1: addr = 7'h0F;
                2: addr = 7'h10;
                3: addr = 7'h11;
                4: addr = 7'h22;
                5: addr = 7'h23;
                default: addr = 7'($urandom);
            endcase
            wr   = 1'($urandom_range(0, 1));
            data = 8'($urandom);
            if (wr && addr == 7'h0D && data == 8'h02) data = 8'h03;
            e0 = err_pulses;
            spi_frame({~wr, addr, wr ? data : 8'h00}, 16, 1'b1, 0, r);
            clks(10);
            if (wr) begin
                if (addr == 7'h0D || addr == 7'h10 || addr == 7'h11) mdl[addr] = data;
            end else begin
                chk($sformatf("rnd%0d_rd_%h", k, addr), 32'(r[7:0]),
                    32'((addr == 7'h0F) ? WHO : mdl[addr]));
            end
            if (err_pulses != e0) chk($sformatf("rnd%0d_err", k), 32'(err_pulses - e0), 32'd0);
        end
        chk("rnd_setup", 32'(setup_done), 32'd0);
        chk("rnd_int", 32'(INT), 32'd0);

        // Enable sampling: setup_done 3 clk after SS_n rise, INT P clk later
        ptch_smpl = 16'hF3A5;
        spi_frame(16'h0D02, 16, 1'b1, 0, r);
        t = 0;
        while (!setup_done && t < 10) begin clks(1); t++; end
        chk("setup_lat", 32'(t), 32'd3);
        t = 0;
        while (!INT && t < int'(P) + 20) begin clks(1); t++; end
        chk("int_lat", 32'(t), 32'(P));

        // Pitch readback; INT clears only once the PITCHH read completes
        rd(7'h22, b);
        chk("pitchl", 32'(b), 32'hA5);
        chk("int_after_pitchl", 32'(INT), 32'd1);
        spi_frame(16'hA300, 16, 1'b1, 0, r);
        chk("pitchh", 32'(r[7:0]), 32'hF3);
        clks(2);
        chk("int_before_clr", 32'(INT), 32'd1);
        clks(1);
        chk("int_cleared", 32'(INT), 32'd0);

        // Land the PITCHH-read clear on the same clk as the next tick
        t = 0;
        while (!INT && t < int'(P) + 20) begin clks(1); t++; end
        chk("int_second_tick", 32'(INT), 32'd1);
        c2 = cyc;
        spi_frame(16'hA300, 16, 1'b1, c2 + int'(P) - 3, r);
        chk("raise_aligned", 32'(cyc), 32'(c2 + int'(P) - 3));
        clks(3);
        chk("int_tick_wins", 32'(INT), 32'd1);
        clks(3);
        chk("int_tick_wins_hold", 32'(INT), 32'd1);
        rd(7'h23, b);
        chk("int_clear_again", 32'(INT), 32'd0);

        // Reset in the middle of a write: back to IDLE, nothing written
        e0 = err_pulses;
        spi_frame(16'h1077, 12, 1'b0, 0, r);
        rst = 1'b1;
        clks(2);
        chk("midrst_miso", 32'(MISO), 32'd1);
        chk("midrst_int", 32'(INT), 32'd0);
        chk("midrst_setup", 32'(setup_done), 32'd0);
        SS_n = 1'b1; SCLK = 1'b1;
        clks(2);
        rst = 1'b0;
        clks(5);
        chk("midrst_no_err", 32'(err_pulses - e0), 32'd0);
        rd(7'h10, b);
        chk("midrst_no_write", 32'(b), 32'h00);
        rd(7'h0F, b);
        chk("midrst_whoami", 32'(b), 32'h6A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
